// File: rtl/vga_scanout.sv
`default_nettype none
// ============================================================================
// Module   : vga_scanout
// Brief    : VGA raster timing generator with pixel-coordinate requests,
//            latency-matched sync/DE delay line and registered colour output.
// Revision : 1.0  initial release
// ============================================================================
module vga_scanout #(
    parameter int width_p              = 640,
    parameter int height_p             = 480,
    parameter int h_sync_pulse_p       = 96,
    parameter int h_sync_back_porch_p  = 48,
    parameter int h_sync_front_porch_p = 16,
    parameter int v_sync_pulse_p       = 2,
    parameter int v_sync_back_porch_p  = 33,
    parameter int v_sync_front_porch_p = 10,
    parameter int color_width_p        = 8,
    parameter int pixel_lat_p          = 1,
    parameter int hs_active_high_p     = 0,
    parameter int vs_active_high_p     = 0
) (
    input  logic                                                   clk_i,
    input  logic                                                   reset_i,
    input  logic                                                   enable_i,
    input  logic [color_width_p-1:0]                               r_i,
    input  logic [color_width_p-1:0]                               g_i,
    input  logic [color_width_p-1:0]                               b_i,
    output logic [((width_p  > 1) ? $clog2(width_p)  : 1)-1:0]     x_o,
    output logic [((height_p > 1) ? $clog2(height_p) : 1)-1:0]     y_o,
    output logic                                                   xy_v_o,
    output logic                                                   frame_start_o,
    output logic [color_width_p-1:0]                               r_o,
    output logic [color_width_p-1:0]                               g_o,
    output logic [color_width_p-1:0]                               b_o,
    output logic                                                   de_o,
    output logic                                                   hs_o,
    output logic                                                   vs_o,
    output logic                                                   running_o
);

    localparam int XW  = (width_p  > 1) ? $clog2(width_p)  : 1;
    localparam int YW  = (height_p > 1) ? $clog2(height_p) : 1;
    localparam int H   = h_sync_pulse_p + h_sync_back_porch_p + width_p + h_sync_front_porch_p;
    localparam int V   = v_sync_pulse_p + v_sync_back_porch_p + height_p + v_sync_front_porch_p;
    localparam int HCW = $clog2(H);
    localparam int VCW = $clog2(V);
    localparam int HA  = h_sync_pulse_p + h_sync_back_porch_p;
    localparam int VA  = v_sync_pulse_p + v_sync_back_porch_p;

    // Active-area bounds never exceed the last count, so they fit the counter width.
    localparam logic [HCW-1:0] H_LAST  = HCW'(H - 1);
    localparam logic [VCW-1:0] V_LAST  = VCW'(V - 1);
    localparam logic [HCW-1:0] HA_C    = HCW'(HA);
    localparam logic [HCW-1:0] HE_C    = HCW'(HA + width_p);
    localparam logic [VCW-1:0] VA_C    = VCW'(VA);
    localparam logic [VCW-1:0] VE_C    = VCW'(VA + height_p);
    localparam logic [HCW-1:0] HS_END  = HCW'(h_sync_pulse_p);
    localparam logic [VCW-1:0] VS_END  = VCW'(v_sync_pulse_p);
    localparam logic           HS_IDLE = (hs_active_high_p != 0) ? 1'b0 : 1'b1;
    localparam logic           VS_IDLE = (vs_active_high_p != 0) ? 1'b0 : 1'b1;

    if (pixel_lat_p < 0 || pixel_lat_p > 8) begin : g_bad_latency
        $error("vga_scanout: pixel_lat_p must be within 0..8");
    end
    if (width_p <= 0 || height_p <= 0 ||
        h_sync_pulse_p <= 0 || h_sync_back_porch_p <= 0 || h_sync_front_porch_p <= 0 ||
        v_sync_pulse_p <= 0 || v_sync_back_porch_p <= 0 || v_sync_front_porch_p <= 0) begin : g_bad_timing
        $error("vga_scanout: timing parameters must be non-zero");
    end

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state;
    logic [HCW-1:0] hcnt;
    logic [VCW-1:0] vcnt;
    logic           is_run;
    logic           h_end;
    logic           v_end;
    logic [2:0]     raw;   // {hsync, vsync, de}
    logic [2:0]     del;

    assign is_run = (state == RUN);
    assign h_end  = (hcnt == H_LAST);
    assign v_end  = (vcnt == V_LAST);

    // Scan FSM and raster counters; enable is only honoured at the last pixel of a frame.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= IDLE;
            hcnt  <= '0;
            vcnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    hcnt <= '0;
                    vcnt <= '0;
                    if (enable_i) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (h_end) begin
                        hcnt <= '0;
                        if (v_end) begin
                            vcnt <= '0;
                            if (!enable_i) begin
                                state <= IDLE;
                            end
                        end else begin
                            vcnt <= vcnt + 1'b1;
                        end
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    hcnt  <= '0;
                    vcnt  <= '0;
                end
            endcase
        end
    end

    assign running_o     = is_run;
    assign xy_v_o        = is_run && (hcnt >= HA_C) && (hcnt < HE_C) &&
                           (vcnt >= VA_C) && (vcnt < VE_C);
    assign x_o           = XW'(hcnt - HA_C);
    assign y_o           = YW'(vcnt - VA_C);
    assign frame_start_o = is_run && (hcnt == '0) && (vcnt == '0);
    assign raw           = {is_run && (hcnt < HS_END), is_run && (vcnt < VS_END), xy_v_o};

    if (pixel_lat_p == 0) begin : g_no_delay
        assign del = raw;
    end else begin : g_delay
        logic [2:0] pipe [pixel_lat_p];

        // Delay sync/DE by the colour source latency so they line up with r_i/g_i/b_i.
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                for (int i = 0; i < pixel_lat_p; i++) begin
                    pipe[i] <= '0;
                end
            end else begin
                pipe[0] <= raw;
                for (int i = 1; i < pixel_lat_p; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
        end

        assign del = pipe[pixel_lat_p-1];
    end

    // Output register: polarity applied here, colour blanked outside the active area.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hs_o <= HS_IDLE;
            vs_o <= VS_IDLE;
            de_o <= 1'b0;
            r_o  <= '0;
            g_o  <= '0;
            b_o  <= '0;
        end else begin
            hs_o <= (hs_active_high_p != 0) ? del[2] : ~del[2];
            vs_o <= (vs_active_high_p != 0) ? del[1] : ~del[1];
            de_o <= del[0];
            r_o  <= del[0] ? r_i : '0;
            g_o  <= del[0] ? g_i : '0;
            b_o  <= del[0] ? b_i : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_scanout.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_scanout
// Brief    : Directed scoreboard bench for vga_scanout (4x3 raster, latency 2).
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_scanout;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] r_in, g_in, b_in;

    logic [1:0] x, y, x2, y2;
    logic       xy_v, fs, de, hs, vs, run;
    logic       xy_v2, fs2, de2, hs2, vs2, run2;
    logic [7:0] ro, go, bo, ro2, go2, bo2;

    int checks = 0;
    int errors = 0;
    bit mon_on = 1'b0;
    logic [23:0] exp_q [$];
    logic [23:0] exp_px;
    logic [4:0]  d1, d2;   // colour source pipeline {valid, x, y}

    always #5 clk = ~clk;

    vga_scanout #(
        .width_p(4), .height_p(3),
        .h_sync_pulse_p(1), .h_sync_back_porch_p(1), .h_sync_front_porch_p(1),
        .v_sync_pulse_p(1), .v_sync_back_porch_p(1), .v_sync_front_porch_p(1),
        .color_width_p(8), .pixel_lat_p(2),
        .hs_active_high_p(0), .vs_active_high_p(0)
    ) dut (
        .clk_i(clk), .reset_i(rst), .enable_i(en),
        .r_i(r_in), .g_i(g_in), .b_i(b_in),
        .x_o(x), .y_o(y), .xy_v_o(xy_v), .frame_start_o(fs),
        .r_o(ro), .g_o(go), .b_o(bo),
        .de_o(de), .hs_o(hs), .vs_o(vs), .running_o(run)
    );

    vga_scanout #(
        .width_p(4), .height_p(3),
        .h_sync_pulse_p(1), .h_sync_back_porch_p(1), .h_sync_front_porch_p(1),
        .v_sync_pulse_p(1), .v_sync_back_porch_p(1), .v_sync_front_porch_p(1),
        .color_width_p(8), .pixel_lat_p(2),
        .hs_active_high_p(1), .vs_active_high_p(0)
    ) dut_hi (
        .clk_i(clk), .reset_i(rst), .enable_i(en),
        .r_i(r_in), .g_i(g_in), .b_i(b_in),
        .x_o(x2), .y_o(y2), .xy_v_o(xy_v2), .frame_start_o(fs2),
        .r_o(ro2), .g_o(go2), .b_o(bo2),
        .de_o(de2), .hs_o(hs2), .vs_o(vs2), .running_o(run2)
    );

    // Colour source with two cycles of latency: r = column, g = row, b = 0x5A.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            d1 <= '0;
            d2 <= '0;
        end else begin
            d1 <= {xy_v, x, y};
            d2 <= d1;
        end
    end
    assign r_in = d2[4] ? {6'd0, d2[3:2]} : 8'hEE;
    assign g_in = d2[4] ? {6'd0, d2[1:0]} : 8'hEE;
    assign b_in = d2[4] ? 8'h5A : 8'hEE;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_frame();
        for (int yy = 0; yy < 3; yy++) begin
            for (int xx = 0; xx < 4; xx++) begin
                exp_q.push_back({8'(xx), 8'(yy), 8'h5A});
            end
        end
    endtask

    // Monitor: every displayed pixel is matched against the scoreboard; blanking must be black.
    always @(negedge clk) begin
        if (mon_on && !rst) begin
            if (de) begin
                if (exp_q.size() == 0) begin
                    chk("pixel_unexpected", 1, 0);
                end else begin
                    exp_px = exp_q.pop_front();
                    chk("pixel_rgb", {8'd0, ro, go, bo}, {8'd0, exp_px});
                end
            end else begin
                chk("blank_black", {8'd0, ro, go, bo}, 0);
            end
        end
    end

    initial begin
        int n, h, v, q, nq, vcount;
        bit act, ev_xy, eh, ev, ed;
        rst = 1'b1;
        en  = 1'b0;
        vcount = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_de", de, 0);
        chk("rst_hs", hs, 1);
        chk("rst_vs", vs, 1);
        chk("rst_rgb", {ro, go, bo}, 0);
        chk("rst_running", run, 0);
        chk("rst_xy_v", xy_v, 0);
        chk("rst_fs", fs, 0);
        chk("rst_hs_hi", hs2, 0);

        rst = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);
        chk("idle_running", run, 0);
        en = 1'b1;
        @(negedge clk);

        // Three frames; enable drops mid third frame, which must still complete.
        for (int off = 0; off < 136; off++) begin
            n   = off % 42;
            h   = n % 7;
            v   = n / 7;
            act = (off < 126);
            if (act && n == 0) push_frame();
            chk("frame_start", fs, act && n == 0);
            chk("running", run, act);
            ev_xy = act && h >= 2 && h <= 5 && v >= 2 && v <= 4;
            chk("xy_v", xy_v, ev_xy);
            if (ev_xy) begin
                chk("x", x, h - 2);
                chk("y", y, v - 2);
                vcount++;
            end
            if (act && n == 41) begin
                chk("xy_per_frame", vcount, 12);
                vcount = 0;
            end
            q = off - 3;
            if (q >= 0 && q < 126) begin
                nq = q % 42;
                eh = (nq % 7) != 0;
                ev = (nq / 7) != 0;
                ed = (nq % 7) >= 2 && (nq % 7) <= 5 && (nq / 7) >= 2 && (nq / 7) <= 4;
            end else begin
                eh = 1'b1;
                ev = 1'b1;
                ed = 1'b0;
            end
            chk("hs", hs, eh);
            chk("vs", vs, ev);
            chk("de", de, ed);
            chk("hs_hi", hs2, !eh);
            chk("vs_hi", vs2, ev);
            if (off == 94) en = 1'b0;
            @(negedge clk);
        end

        // Reset in the middle of an active line.
        en = 1'b1;
        @(negedge clk);
        chk("restart_fs", fs, 1);
        push_frame();
        repeat (19) @(negedge clk);
        chk("pre_reset_de", de, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midreset_de", de, 0);
        chk("midreset_hs", hs, 1);
        chk("midreset_vs", vs, 1);
        chk("midreset_rgb", {ro, go, bo}, 0);
        chk("midreset_running", run, 0);
        chk("midreset_xy_v", xy_v, 0);
        chk("midreset_hs_hi", hs2, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_fs", fs, 1);
        push_frame();
        en = 1'b0;
        repeat (41) @(negedge clk);
        chk("last_frame_running", run, 1);
        @(negedge clk);
        chk("stop_running", run, 0);
        chk("stop_fs", fs, 0);
        repeat (3) @(negedge clk);
        chk("stop_de", de, 0);
        chk("stop_hs", hs, 1);
        chk("stop_vs", vs, 1);
        chk("stop_rgb", {ro, go, bo}, 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
